ens0_layer1_input_stage: RTL and testbench
==========================================

ENS0_LAYER1_INPUT_STAGE -- requirements
Module: ens0_layer1_input_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 256: bit width of the layer0 output vector presented to the layer1 neuron LUTs.
REQ-002 SHALL have parameter CNT_W, default 32: width of the accepted-vector counter.
REQ-003 SHALL have port clk  input  1  single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port s_valid  input  1  layer0 vector valid.
REQ-006 SHALL have port s_ready  output  1  stage can accept a vector this cycle.
REQ-007 SHALL have port s_data  input  WIDTH  layer0 output vector.
REQ-008 SHALL have port m_valid  output  1  vector valid toward layer1.
REQ-009 SHALL have port m_ready  input  1  layer1 side (downstream register) accepts.
REQ-010 SHALL have port m_data  output  WIDTH  registered vector; slices feed the 8-bit layer1 neuron LUT inputs.
REQ-011 SHALL have port vec_count  output  CNT_W  number of vectors accepted on the s side since reset.

Function
REQ-012 SHALL transfer on the s side when s_valid and s_ready are both 1 at a rising edge; likewise on the m side with m_valid and m_ready.
REQ-013 SHALL implement a two-entry skid buffer: main register (drives m_data) plus skid register.
REQ-014 SHALL use states EMPTY (0 held), ONE (main valid), FULL (main and skid valid).
REQ-015 SHALL drive m_valid = 1 in ONE and FULL; 0 in EMPTY.
REQ-016 SHALL drive s_ready from a register: 1 in EMPTY and ONE, 0 in FULL; never combinationally from m_ready.
REQ-017 EMPTY: s-transfer -> load main, go ONE.
REQ-018 ONE: s-transfer with no m-transfer -> load skid, go FULL; m-transfer with no s-transfer -> go EMPTY; both -> load main with s_data, stay ONE.
REQ-019 FULL: m-transfer -> move skid into main, go ONE; no s-transfer possible.
REQ-020 SHALL have latency of exactly 1 cycle from s-transfer into EMPTY to m_valid = 1.
REQ-021 SHALL preserve order and never drop or duplicate vectors; m_data SHALL stay stable while m_valid = 1 and m_ready = 0.
REQ-022 SHALL sustain one vector per cycle when m_ready is held 1.
REQ-023 SHALL increment vec_count by 1 on each s-transfer and saturate at all-ones (no wrap-around).
REQ-024 SHALL ignore s_data when no s-transfer occurs; skid contents SHALL be don't-care outside FULL.

Reset
REQ-025 SHALL, while rst = 1, force state EMPTY, m_valid = 0, s_ready = 0, vec_count = 0, m_data = 0, independent of clk.
REQ-026 SHALL raise s_ready = 1 on the first rising edge after rst deasserts.
REQ-027 SHALL discard any in-flight vectors when rst asserts mid-operation; no partial transfer completes.

Structure
REQ-028 SHALL place the state encoding (EMPTY/ONE/FULL) and default WIDTH/CNT_W constants in the shared logicnets package used by all ens*_layer* stages.
REQ-029 SHALL be one flat module; the saturating counter MAY be a sub-module named sat_counter.
REQ-030 SHALL contain no combinational path from m_ready to s_ready or from s_data to m_data.

Verification
REQ-031 Single vector: after reset, s_data = 0xA5 pattern, one-cycle s_valid, m_ready = 1 -> m_valid next cycle, m_data = 0xA5 pattern, vec_count = 1.
REQ-032 Backpressure: m_ready = 0, send vectors 1,2,3 back-to-back -> vectors 1,2 accepted, s_ready = 0 on 3rd cycle, m_data holds 1; release m_ready -> 1,2,3 out in order.
REQ-033 Streaming: 100 vectors with s_valid and m_ready held 1 -> 100 outputs, one per cycle, in order, vec_count = 100.
REQ-034 Random valid/ready toggling (10k cycles) against a scoreboard queue -> zero loss, zero duplication, m_data stable under stall.
REQ-035 Reset mid-operation: FULL state, assert rst asynchronously between edges -> m_valid and s_ready fall immediately, vec_count = 0; post-reset vectors only.
REQ-036 Saturation: CNT_W = 4, send 20 vectors -> vec_count stops at 15.

Source files
------------

// File: rtl/ens0_layer1_input_stage_pkg.sv
// Shared constants and state encoding for the ens*_layer* input stages.
package ens0_layer1_input_stage_pkg;

  localparam int DEF_WIDTH = 256;
  localparam int DEF_CNT_W = 32;

  // Skid-buffer occupancy: nothing held, main only, main plus skid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_e;

endpackage

// File: rtl/ens0_layer1_input_stage_sat_counter.sv
// Saturating up-counter: counts inc pulses, holds at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count up on inc unless already at the maximum value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/ens0_layer1_input_stage.sv
// Layer1 input stage: two-entry skid buffer between layer0 output and the
// layer1 neuron LUTs, with fully registered handshake outputs and an
// accepted-vector counter.
module ens0_layer1_input_stage
  import ens0_layer1_input_stage_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [CNT_W-1:0] vec_count
);

  stage_state_e     state_r;
  logic [WIDTH-1:0] main_r;
  logic [WIDTH-1:0] skid_r;
  logic             m_valid_r;
  logic             s_ready_r;
  logic             s_xfer_s;
  logic             m_xfer_s;

  // Handshakes use only registered ready/valid, so m_ready never reaches s_ready.
  assign s_xfer_s = s_valid & s_ready_r;
  assign m_xfer_s = m_valid_r & m_ready;

  assign s_ready = s_ready_r;
  assign m_valid = m_valid_r;
  assign m_data  = main_r;

  // Occupancy FSM: moves vectors between input, main and skid registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_EMPTY;
      main_r    <= '0;
      skid_r    <= '0;
      m_valid_r <= 1'b0;
      s_ready_r <= 1'b0;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          s_ready_r <= 1'b1;
          if (s_xfer_s) begin
            main_r    <= s_data;
            m_valid_r <= 1'b1;
            state_r   <= ST_ONE;
          end else begin
            m_valid_r <= 1'b0;
          end
        end
        ST_ONE: begin
          if (s_xfer_s && !m_xfer_s) begin
            // Downstream stalled: park the new vector in the skid slot.
            skid_r    <= s_data;
            s_ready_r <= 1'b0;
            m_valid_r <= 1'b1;
            state_r   <= ST_FULL;
          end else if (m_xfer_s && !s_xfer_s) begin
            s_ready_r <= 1'b1;
            m_valid_r <= 1'b0;
            state_r   <= ST_EMPTY;
          end else if (s_xfer_s && m_xfer_s) begin
            main_r    <= s_data;
            s_ready_r <= 1'b1;
            m_valid_r <= 1'b1;
          end else begin
            s_ready_r <= 1'b1;
            m_valid_r <= 1'b1;
          end
        end
        ST_FULL: begin
          if (m_xfer_s) begin
            main_r    <= skid_r;
            s_ready_r <= 1'b1;
            state_r   <= ST_ONE;
          end else begin
            s_ready_r <= 1'b0;
          end
          m_valid_r <= 1'b1;
        end
        default: begin
          state_r   <= ST_EMPTY;
          m_valid_r <= 1'b0;
          s_ready_r <= 1'b1;
        end
      endcase
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_vec_count (
    .clk   (clk),
    .rst   (rst),
    .inc   (s_xfer_s),
    .count (vec_count)
  );

endmodule

// File: tb/tb_ens0_layer1_input_stage.sv
// Self-checking bench for ens0_layer1_input_stage: vector table for the
// single-vector and backpressure cases, queue-based reference model for
// streaming, random handshakes and reset, plus a 4-bit counter instance.
module tb_ens0_layer1_input_stage;

  localparam int W = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid, s_ready, m_valid, m_ready;
  logic [W-1:0]  s_data, m_data;
  logic [31:0]   vec_count;

  logic          sat_s_valid, sat_s_ready, sat_m_valid, sat_m_ready;
  logic [7:0]    sat_s_data, sat_m_data;
  logic [3:0]    sat_count;

  always #5 clk = ~clk;

  ens0_layer1_input_stage dut (
    .clk (clk), .rst (rst),
    .s_valid (s_valid), .s_ready (s_ready), .s_data (s_data),
    .m_valid (m_valid), .m_ready (m_ready), .m_data (m_data),
    .vec_count (vec_count)
  );

  ens0_layer1_input_stage #(.WIDTH(8), .CNT_W(4)) u_sat (
    .clk (clk), .rst (rst),
    .s_valid (sat_s_valid), .s_ready (sat_s_ready), .s_data (sat_s_data),
    .m_valid (sat_m_valid), .m_ready (sat_m_ready), .m_data (sat_m_data),
    .vec_count (sat_count)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the vectors currently held by the stage, oldest first.
  logic [W-1:0]    q[$];
  longint unsigned cnt;
  bit              rdy_en;
  int              dut_xfers;

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         r;
    logic         e_mv;
    logic         e_sr;
    logic         chk_d;
    logic [W-1:0] e_md;
    int           e_cnt;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic model_reset();
    q.delete();
    cnt    = 0;
    rdy_en = 1'b0;
  endtask

  // One clock: drive inputs, predict transfers, then check after the edge.
  task automatic step(input logic v, input logic [W-1:0] d, input logic r);
    logic         sx, mx, stall;
    logic [W-1:0] held;
    s_valid = v;
    s_data  = d;
    m_ready = r;
    sx    = v && rdy_en && (q.size() < 2);
    mx    = r && (q.size() > 0);
    stall = m_valid && !r;
    held  = m_data;
    if (m_valid && r) dut_xfers++;
    @(posedge clk);
    #1;
    if (mx) void'(q.pop_front());
    if (sx) begin
      q.push_back(d);
      if (cnt != 64'hFFFF_FFFF) cnt = cnt + 1;
    end
    rdy_en = 1'b1;
    chk("m_valid", W'(m_valid), W'(q.size() > 0));
    chk("s_ready", W'(s_ready), W'(q.size() < 2));
    chk("vec_count", W'(vec_count), W'(cnt));
    if (q.size() > 0) chk("m_data", m_data, q[0]);
    if (stall) chk("stall_hold", m_data, held);
  endtask

  // Assert reset between clock edges; outputs must drop without a clock.
  task automatic apply_reset();
    #3;
    rst = 1'b1;
    model_reset();
    s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
    sat_s_valid = 1'b0; sat_m_ready = 1'b0; sat_s_data = 8'd0;
    #1;
    chk("rst_m_valid", W'(m_valid), W'(1'b0));
    chk("rst_s_ready", W'(s_ready), W'(1'b0));
    chk("rst_vec_count", W'(vec_count), W'(0));
    chk("rst_m_data", m_data, W'(0));
    chk("rst_sat_count", W'(sat_count), W'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("s_ready_low_at_release", W'(s_ready), W'(1'b0));
    step(1'b0, '0, 1'b0);
  endtask

  initial begin
    tbl[0] = '{1'b1, {32{8'hA5}}, 1'b1, 1'b1, 1'b1, 1'b1, {32{8'hA5}}, 1};
    tbl[1] = '{1'b0, W'(0),       1'b1, 1'b0, 1'b1, 1'b0, W'(0),       1};
    tbl[2] = '{1'b1, W'(1),       1'b0, 1'b1, 1'b1, 1'b1, W'(1),       2};
    tbl[3] = '{1'b1, W'(2),       1'b0, 1'b1, 1'b0, 1'b1, W'(1),       3};
    tbl[4] = '{1'b1, W'(3),       1'b0, 1'b1, 1'b0, 1'b1, W'(1),       3};
    tbl[5] = '{1'b1, W'(3),       1'b1, 1'b1, 1'b1, 1'b1, W'(2),       3};
    tbl[6] = '{1'b1, W'(3),       1'b1, 1'b1, 1'b1, 1'b1, W'(3),       4};
    tbl[7] = '{1'b0, W'(9),       1'b1, 1'b0, 1'b1, 1'b0, W'(0),       4};

    rst = 1'b1;
    s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
    sat_s_valid = 1'b0; sat_m_ready = 1'b0; sat_s_data = 8'd0;
    dut_xfers = 0;
    @(posedge clk);
    #1;
    apply_reset();

    // Single vector followed by the three-vector backpressure sequence.
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].r);
      chk($sformatf("tbl%0d_m_valid", i), W'(m_valid), W'(tbl[i].e_mv));
      chk($sformatf("tbl%0d_s_ready", i), W'(s_ready), W'(tbl[i].e_sr));
      chk($sformatf("tbl%0d_vec_count", i), W'(vec_count), W'(tbl[i].e_cnt));
      if (tbl[i].chk_d) chk($sformatf("tbl%0d_m_data", i), m_data, tbl[i].e_md);
    end

    // Streaming: 100 vectors at full rate.
    apply_reset();
    dut_xfers = 0;
    for (int i = 0; i < 100; i++) step(1'b1, W'(i + 1), 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    chk("stream_outputs", W'(dut_xfers), W'(100));
    chk("stream_vec_count", W'(vec_count), W'(100));

    // Random valid/ready toggling against the model.
    apply_reset();
    dut_xfers = 0;
    for (int i = 0; i < 10000; i++)
      step(1'($urandom_range(0, 1)), rand_vec(), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
    chk("random_drained", W'(m_valid), W'(1'b0));
    chk("random_no_loss_dup", W'(dut_xfers), W'(vec_count));

    // Reset while FULL: in-flight vectors vanish, only new ones emerge.
    step(1'b1, W'(256'hAAAA), 1'b0);
    step(1'b1, W'(256'hBBBB), 1'b0);
    chk("full_before_reset", W'(s_ready), W'(1'b0));
    apply_reset();
    step(1'b1, W'(256'hCCCC), 1'b0);
    chk("post_reset_data", m_data, W'(256'hCCCC));
    step(1'b0, '0, 1'b1);
    chk("post_reset_drained", W'(m_valid), W'(1'b0));
    chk("post_reset_count", W'(vec_count), W'(1));

    // 4-bit counter saturates at 15 after 20 accepted vectors.
    for (int k = 1; k <= 20; k++) begin
      sat_s_valid = 1'b1;
      sat_m_ready = 1'b1;
      sat_s_data  = 8'(k);
      @(posedge clk);
      #1;
      chk($sformatf("sat_count_%0d", k), W'(sat_count), W'((k > 15) ? 15 : k));
      chk($sformatf("sat_m_data_%0d", k), W'(sat_m_data), W'(k));
    end
    sat_s_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
